// File: rtl/gcd_operand_sequencer_if.sv
// Stream and core-control signals shared between the GCD operand sequencer and its environment.
// master is the sequencer side; slave is the producer/consumer/core side.
interface gcd_operand_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic             core_rst;
    logic             core_start;
    logic [WIDTH-1:0] core_data;
    logic             core_done;
    logic [WIDTH-1:0] core_result;

    modport master (
        input  in_valid, in_a, in_b, out_ready, core_done, core_result,
        output in_ready, out_valid, out_gcd, out_err, core_rst, core_start, core_data
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, core_done, core_result,
        input  in_ready, out_valid, out_gcd, out_err, core_rst, core_start, core_data
    );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// Buffers (A, B) pairs in a FIFO, feeds each non-trivial pair to the serial GCD core and returns
// the result; zero operands are resolved locally without touching the core.
module gcd_operand_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                     clk,
    input logic                     rst,
    gcd_operand_sequencer_if.master bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCrst  = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StLoadA = 3'd3;
    localparam logic [2:0] StLoadB = 3'd4;
    localparam logic [2:0] StWait  = 3'd5;
    localparam logic [2:0] StOut   = 3'd6;

    logic [WIDTH-1:0] fifo_a_q [DEPTH];
    logic [WIDTH-1:0] fifo_b_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             full, empty, push, pop;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             err_q, err_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // Full refuses a push even when the FSM pops in the same cycle.
    assign push  = bus.in_valid & ~full;
    assign pop   = (state_q == StIdle) & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= bus.in_a;
            fifo_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    a_d = fifo_a_q[rd_ptr_q];
                    b_d = fifo_b_q[rd_ptr_q];
                    if (a_d == '0 && b_d == '0) begin
                        gcd_d   = '0;
                        err_d   = 1'b1;
                        state_d = StOut;
                    end else if (a_d == '0) begin
                        gcd_d   = b_d;
                        err_d   = 1'b0;
                        state_d = StOut;
                    end else if (b_d == '0) begin
                        gcd_d   = a_d;
                        err_d   = 1'b0;
                        state_d = StOut;
                    end else begin
                        state_d = StCrst;
                    end
                end
            end
            StCrst:  state_d = StStart;
            StStart: state_d = StLoadA;
            StLoadA: state_d = StLoadB;
            StLoadB: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // done takes priority over an expiring timeout in the same cycle
                if (bus.core_done) begin
                    gcd_d   = bus.core_result;
                    err_d   = 1'b0;
                    state_d = StOut;
                end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = StOut;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StOut: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = (state_q == StOut);
    assign bus.out_gcd    = gcd_q;
    assign bus.out_err    = err_q;
    assign bus.core_rst   = rst | (state_q == StCrst);
    assign bus.core_start = (state_q == StStart) | (state_q == StLoadA) |
                            (state_q == StLoadB) | (state_q == StWait);

    always_comb begin
        bus.core_data = '0;
        if (state_q == StLoadA) begin
            bus.core_data = a_q;
        end else if (state_q == StLoadB || state_q == StWait) begin
            bus.core_data = b_q;
        end
    end
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a behavioural serial GCD core model.
module tb_gcd_operand_sequencer;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 1023;
    localparam int          CoreLat = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hang = 1'b0;
    always #5 clk = ~clk;

    gcd_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

    gcd_operand_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < 64 && y != 0; i++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: latches A and B on the two cycles after start, reports done CoreLat later.
    int          phase_q;
    logic [15:0] a_lat_q, b_lat_q, res_q;
    logic        done_q;
    assign bus.core_done   = done_q;
    assign bus.core_result = res_q;

    always @(posedge clk or posedge rst) begin
        if (rst || bus.core_rst) begin
            phase_q <= 0;
            done_q  <= 1'b0;
            res_q   <= '0;
            a_lat_q <= '0;
            b_lat_q <= '0;
        end else if (bus.core_start) begin
            phase_q <= phase_q + 1;
            if (phase_q == 1) a_lat_q <= bus.core_data;
            if (phase_q == 2) b_lat_q <= bus.core_data;
            if (phase_q == 3) res_q <= a_lat_q;
            if (phase_q == 2 + CoreLat && !hang) begin
                done_q <= 1'b1;
                res_q  <= gcd_ref(a_lat_q, b_lat_q);
            end
        end
    end

    // Output-stream monitor and core_start activity counter
    int          res_wr = 0;
    int          start_cyc = 0;
    logic [15:0] res_g [64];
    logic        res_e [64];
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready && res_wr < 64) begin
            res_g[res_wr] <= bus.out_gcd;
            res_e[res_wr] <= bus.out_err;
            res_wr        <= res_wr + 1;
        end
        if (bus.core_start) start_cyc <= start_cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rd      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {31'b0, bus.in_ready}, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.core_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", {31'b0, bus.core_start}, 1);
    endtask

    task automatic get_result(input string tag, input logic [15:0] eg, input logic ee);
        int n;
        n = 0;
        while (res_wr <= rd && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_avail"}, {31'b0, res_wr > rd}, 1);
        if (res_wr > rd) begin
            check({tag, "_gcd"}, {16'b0, res_g[rd]}, {16'b0, eg});
            check({tag, "_err"}, {31'b0, res_e[rd]}, {31'b0, ee});
            rd++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s0, acc, stable;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_out_valid",  {31'b0, bus.out_valid}, 0);
        check("rst_out_gcd",    {16'b0, bus.out_gcd}, 0);
        check("rst_out_err",    {31'b0, bus.out_err}, 0);
        check("rst_core_start", {31'b0, bus.core_start}, 0);
        check("rst_core_data",  {16'b0, bus.core_data}, 0);
        check("rst_core_rst",   {31'b0, bus.core_rst}, 1);
        check("rst_in_ready",   {31'b0, bus.in_ready}, 1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_core_rst", {31'b0, bus.core_rst}, 0);

        // Basic pair with output backpressure
        push(16'd143, 16'd78);
        wait_start();
        check("start_data", {16'b0, bus.core_data}, 0);
        @(negedge clk);
        check("load_a_data", {16'b0, bus.core_data}, 143);
        @(negedge clk);
        check("load_b_data", {16'b0, bus.core_data}, 78);
        @(negedge clk);
        check("wait_start_held", {31'b0, bus.core_start}, 1);
        check("wait_data_held", {16'b0, bus.core_data}, 78);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("basic_valid", {31'b0, bus.out_valid}, 1);
        check("basic_gcd_live", {16'b0, bus.out_gcd}, 13);
        check("basic_err_live", {31'b0, bus.out_err}, 0);
        s0 = start_cyc;
        stable = 1;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_a = 16'd48;
        bus.in_b = 16'd18;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) acc = int'(bus.in_ready);
            @(negedge clk);
            if (i == 0) bus.in_valid = 1'b0;
            if (!bus.out_valid || bus.out_gcd != 16'd13 || bus.out_err) stable = 0;
        end
        check("bp_accept", acc, 1);
        check("bp_stable", stable, 1);
        check("bp_no_start", start_cyc - s0, 0);
        bus.out_ready = 1'b1;
        get_result("basic", 16'd13, 1'b0);
        get_result("bp_next", 16'd6, 1'b0);

        // Zero operands
        s0 = start_cyc;
        push(16'd0, 16'd35);
        push(16'd0, 16'd0);
        push(16'd21, 16'd0);
        get_result("zero_b", 16'd35, 1'b0);
        get_result("zero_both", 16'd0, 1'b1);
        get_result("zero_a", 16'd21, 1'b0);
        repeat (3) @(negedge clk);
        check("zero_no_start", start_cyc - s0, 0);

        // FIFO full and ordering: first pair is popped, four more fill the FIFO
        push(16'd48, 16'd18);
        push(16'd17, 16'd5);
        push(16'd100, 16'd75);
        push(16'd9, 16'd9);
        push(16'd64, 16'd40);
        check("fifo_full_ready", {31'b0, bus.in_ready}, 0);
        push(16'd81, 16'd27);
        get_result("ord0", 16'd6, 1'b0);
        get_result("ord1", 16'd1, 1'b0);
        get_result("ord2", 16'd25, 1'b0);
        get_result("ord3", 16'd9, 1'b0);
        get_result("ord4", 16'd8, 1'b0);
        get_result("ord5", 16'd27, 1'b0);

        // Timeout: START, LOAD_A, LOAD_B, then 1023 WAIT cycles before OUT
        bus.out_ready = 1'b0;
        hang = 1'b1;
        push(16'd143, 16'd78);
        wait_start();
        n = 0;
        while (!bus.out_valid && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, 1026);
        check("tmo_gcd_live", {16'b0, bus.out_gcd}, 0);
        check("tmo_err_live", {31'b0, bus.out_err}, 1);
        hang = 1'b0;
        bus.out_ready = 1'b1;
        get_result("tmo", 16'd0, 1'b1);
        push(16'd100, 16'd75);
        get_result("after_tmo", 16'd25, 1'b0);

        // Reset while in WAIT with another pair queued
        hang = 1'b1;
        push(16'd143, 16'd78);
        push(16'd5, 16'd5);
        wait_start();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_core_rst", {31'b0, bus.core_rst}, 1);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 0);
        check("midrst_core_start", {31'b0, bus.core_start}, 0);
        hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s0 = start_cyc;
        repeat (4) @(negedge clk);
        check("midrst_fifo_empty", start_cyc - s0, 0);
        check("midrst_no_result", res_wr - rd, 0);
        push(16'd12, 16'd8);
        get_result("after_rst", 16'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
- Upstream feeder for the GCD datapath/controller pair.
- Accepts (A, B) operand pairs on a valid/ready stream and buffers them in a small FIFO.
- For each pair, resets and starts the GCD core, then drives A and B on its shared serial `data_in` bus in consecutive cycles.
- Waits for `done`, then returns the result (or an error) on a valid/ready output stream. Zero operands are handled locally, never sent to the core.

Parameters:
- WIDTH, 16, operand/result width; matches the core `data_in` bus.
- DEPTH, 4, operand-pair FIFO depth; power of two, at least 2.
- TIMEOUT, 1023, maximum cycles spent in WAIT before aborting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept a pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_gcd  output  WIDTH  GCD result.
- out_err  output  1  result invalid (both operands zero, or timeout).
- core_rst  output  1  reset to GCD controller.
- core_start  output  1  start to GCD controller.
- core_data  output  WIDTH  drives core `data_in`.
- core_done  input  1  core `done`; stays high once set, until core_rst.
- core_result  input  WIDTH  core A-register output; the GCD value when core_done=1.

Behaviour:
- **Reset (rst=1):**
  - FIFO empty; state IDLE; cycle counter 0.
  - out_valid=0, out_gcd=0, out_err=0, core_start=0, core_data=0.
  - core_rst=1 (core_rst = rst OR state==CRST).
- **FIFO:**
  - Push when in_valid & in_ready; in_ready = !full.
  - A push is refused when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when neither full nor empty is allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, CRST, START, LOAD_A, LOAD_B, WAIT, OUT.
  - **IDLE:** if FIFO non-empty, pop into a_reg/b_reg.
    - Both operands zero → OUT with gcd=0, err=1.
    - Exactly one operand zero → OUT with gcd = the other operand, err=0.
    - Otherwise → CRST.
  - **CRST:** core_rst=1 for exactly one cycle → START.
  - **START:** core_start=1, core_data=0 → LOAD_A.
  - **LOAD_A:** core_data=a_reg → LOAD_B. The core latches A on the edge ending this cycle.
  - **LOAD_B:** core_data=b_reg → WAIT. The core latches B on the edge ending this cycle. Counter cleared.
  - **WAIT:** core_data holds b_reg; counter increments each cycle.
    - core_done=1 → capture core_result into out_gcd, err=0 → OUT.
    - Otherwise, counter==TIMEOUT-1 → gcd=0, err=1 → OUT.
    - If both occur in the same cycle, done wins.
  - **OUT:** out_valid=1; out_gcd/out_err held stable until out_valid & out_ready → IDLE.
- **core_start:** held 1 in START, LOAD_A, LOAD_B and WAIT; 0 in all other states.
- **Latency and throughput:**
  - A non-zero pair popped at edge N: core_rst is high in cycle N+1, A is on the bus in N+3, B in N+4.
  - out_valid is asserted 1 cycle after core_done is sampled.
  - Zero-bypass pairs reach OUT 1 cycle after the pop.
  - One pair is in flight at a time. The FIFO keeps accepting during processing.
- **Reset mid-operation:** all of the above is cleared immediately. Any pending result and all FIFO contents are discarded.
- **Registered outputs:** outputs change only on clk edges, except core_rst, which follows rst combinationally.

Test Plan:
- **Basic pair:** push (143,78) with a GCD core model → core_data shows 143 then 78 on consecutive cycles after the core_start rise; out_gcd=13, out_err=0; out_valid held until out_ready.
- **Zero operands:** push (0,35) → 35/err=0; push (0,0) → 0/err=1; push (21,0) → 21/err=0. core_start stays 0 throughout.
- **FIFO full and ordering:** push 6 pairs back-to-back, (48,18), (17,5), (100,75), (9,9), (64,40), (81,27), with out_ready=1 → in_ready drops after 4 stored pairs; results arrive in order 6, 1, 25, 9, 8, 27.
- **Timeout:** core model never asserts done, with TIMEOUT=1023 → out_err=1 and out_gcd=0 exactly 1023 cycles after entering WAIT. The next pair still completes correctly.
- **Output backpressure:** out_ready=0 for 20 cycles during the (143,78) result → out_valid/out_gcd stable; FIFO continues accepting; next pair starts only after the handshake.
- **Reset mid-WAIT:** assert rst while (143,78) is in WAIT → core_rst=1 immediately, out_valid=0, FIFO empty. After release, push (12,8) → result 4.
